// File: rtl/reg_cmd_driver.sv
// reg_cmd_driver
// Turns raw DE0 push-buttons and slide switches into clean one-cycle command
// codes for the register block's ctrl/data_input pair. Buttons and switches
// are synchronized, buttons are debounced, press events are arbitrated
// (CLR > LD > DEC > INC) and INC/DEC auto-repeat while held.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   async_reset  asynchronous active-high reset
//   btn_inc      raw button, 1 = pressed
//   btn_dec      raw button, 1 = pressed
//   btn_ld       raw button, 1 = pressed
//   btn_clr      raw button, 1 = pressed
//   sw           raw switches, value captured on LD
//   ctrl         command code to the register, REG_CTRL_NOP when idle
//   data_out     value for the register's data_input
//   cmd_valid    high exactly when ctrl != REG_CTRL_NOP
module reg_cmd_driver #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  localparam int REG_CTRL_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      async_reset,
  input  logic                      btn_inc,
  input  logic                      btn_dec,
  input  logic                      btn_ld,
  input  logic                      btn_clr,
  input  logic [WIDTH-1:0]          sw,
  output logic [REG_CTRL_WIDTH-1:0] ctrl,
  output logic [WIDTH-1:0]          data_out,
  output logic                      cmd_valid
);

  // Command codes shared with the register block.
  localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_NOP = 3'd0;
  localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_INC = 3'd1;
  localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_DEC = 3'd2;
  localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_LD  = 3'd3;
  localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_CLR = 3'd4;

  // Button bit positions inside the packed button vectors.
  localparam int B_INC = 0;
  localparam int B_DEC = 1;
  localparam int B_LD  = 2;
  localparam int B_CLR = 3;

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAXT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(MAXT);

  localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST   = TW'(REPEAT_DELAY - 2);
  localparam logic [TW-1:0] PERIOD_LAST  = TW'(REPEAT_PERIOD - 2);

  typedef enum logic [2:0] {IDLE, ISSUE, DELAY, REPEAT, WAIT_REL} state_t;

  logic [3:0]       btn_s1, btn_s2;
  logic [WIDTH-1:0] sw_s1, sw_s2;
  logic [3:0]       stable, stable_q;
  logic [DW-1:0]    db_cnt [4];
  logic [3:0]       press;

  state_t                    state;
  logic [REG_CTRL_WIDTH-1:0] cmd;
  logic                      repeating;
  logic [TW-1:0]             timer;

  logic [REG_CTRL_WIDTH-1:0] pick;
  logic                      held_level;
  logic [TW-1:0]             threshold;

  // Two-flop synchronizers for buttons and switches.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= {btn_clr, btn_ld, btn_dec, btn_inc};
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: the counter only runs while the synchronized level disagrees
  // with the accepted level, so any agreement restarts the qualification.
  // stable_q is the previous accepted level, used for edge detection.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < 4; i++) begin
        if (btn_s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign press = stable & ~stable_q;

  // Fixed-priority pick among simultaneous presses; losers are dropped.
  always_comb begin
    pick = REG_CTRL_NOP;
    if (press[B_CLR])      pick = REG_CTRL_CLR;
    else if (press[B_LD])  pick = REG_CTRL_LD;
    else if (press[B_DEC]) pick = REG_CTRL_DEC;
    else if (press[B_INC]) pick = REG_CTRL_INC;
  end

  // Accepted level of the button that issued the current command.
  always_comb begin
    held_level = 1'b0;
    case (cmd)
      REG_CTRL_INC: held_level = stable[B_INC];
      REG_CTRL_DEC: held_level = stable[B_DEC];
      REG_CTRL_LD:  held_level = stable[B_LD];
      REG_CTRL_CLR: held_level = stable[B_CLR];
      default:      held_level = 1'b0;
    endcase
  end

  assign threshold = (state == REPEAT) ? PERIOD_LAST : DELAY_LAST;

  // Command FSM. ctrl/cmd_valid are set on the edge that enters ISSUE so the
  // pulse lines up with the ISSUE cycle and defaults back to NOP afterwards.
  // In DELAY/REPEAT the release check precedes the threshold check so a
  // release landing on the threshold cycle suppresses the repeat; a CLR
  // press overrides both.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state     <= IDLE;
      cmd       <= REG_CTRL_NOP;
      repeating <= 1'b0;
      timer     <= '0;
      ctrl      <= REG_CTRL_NOP;
      cmd_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      ctrl      <= REG_CTRL_NOP;
      cmd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|press) begin
            cmd       <= pick;
            repeating <= 1'b0;
            ctrl      <= pick;
            cmd_valid <= 1'b1;
            state     <= ISSUE;
            if (pick == REG_CTRL_LD) data_out <= sw_s2;
          end
        end
        ISSUE: begin
          if (cmd == REG_CTRL_INC || cmd == REG_CTRL_DEC) begin
            timer <= '0;
            state <= repeating ? REPEAT : DELAY;
          end else begin
            state <= WAIT_REL;
          end
        end
        DELAY, REPEAT: begin
          if (press[B_CLR]) begin
            cmd       <= REG_CTRL_CLR;
            repeating <= 1'b0;
            ctrl      <= REG_CTRL_CLR;
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end else if (!held_level) begin
            state <= IDLE;
          end else if (timer == threshold) begin
            repeating <= 1'b1;
            ctrl      <= cmd;
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_REL: begin
          if (press[B_CLR]) begin
            cmd       <= REG_CTRL_CLR;
            repeating <= 1'b0;
            ctrl      <= REG_CTRL_CLR;
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end else if (!held_level) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_driver.sv
// tb_reg_cmd_driver
// Directed bench for reg_cmd_driver with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, WIDTH=8. Inputs change 1 time unit after a rising edge;
// with a button set while the edge counter reads E, its press pulse is
// expected in the cycle after edge E+7 (s1 at E+1, stable at E+6, ISSUE at
// E+7). Pulses are logged by edge number and compared afterwards.
module tb_reg_cmd_driver;

  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] INC = 3'd1;
  localparam logic [2:0] DEC = 3'd2;
  localparam logic [2:0] LD  = 3'd3;
  localparam logic [2:0] CLR = 3'd4;

  logic       clk = 1'b0;
  logic       async_reset;
  logic       btn_inc, btn_dec, btn_ld, btn_clr;
  logic [7:0] sw;
  logic [2:0] ctrl;
  logic [7:0] data_out;
  logic       cmd_valid;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  int         pulseCyc[$];
  logic [2:0] pulseCtrl[$];
  logic [7:0] pulseData[$];
  logic       prevValid = 1'b0;

  reg_cmd_driver #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .async_reset(async_reset),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .btn_ld(btn_ld),
    .btn_clr(btn_clr),
    .sw(sw),
    .ctrl(ctrl),
    .data_out(data_out),
    .cmd_valid(cmd_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Logs every command pulse and checks the valid/ctrl relationship and the
  // no-back-to-back rule on every cycle.
  always @(negedge clk) begin
    vectors++;
    assert ((ctrl !== NOP) === cmd_valid) else begin
      miscompares++;
      $error("[TB] FAIL valid_vs_ctrl: observed ctrl=%0h valid=%0b, expected valid=%0b", ctrl, cmd_valid, ctrl !== NOP);
    end
    vectors++;
    assert (!(cmd_valid === 1'b1 && prevValid === 1'b1)) else begin
      miscompares++;
      $error("[TB] FAIL back_to_back: observed two consecutive valid cycles at edge %0d, expected none", cyc);
    end
    prevValid <= cmd_valid;
    if (cmd_valid === 1'b1) begin
      pulseCyc.push_back(cyc);
      pulseCtrl.push_back(ctrl);
      pulseData.push_back(data_out);
    end
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag, input int base, input int n);
    checkOutput(tag, 32'(pulseCyc.size() - base), 32'(n));
  endtask

  task automatic checkPulse(input string tag, input int idx, input int expCyc,
                            input logic [2:0] expCtrl, input logic [7:0] expData);
    int         oc;
    logic [2:0] octl;
    logic [7:0] od;
    if (idx < pulseCyc.size()) begin
      oc   = pulseCyc[idx];
      octl = pulseCtrl[idx];
      od   = pulseData[idx];
    end else begin
      oc   = -1;
      octl = 3'b111;
      od   = 8'hEE;
    end
    checkOutput({tag, "_cycle"}, 32'(oc), 32'(expCyc));
    checkOutput({tag, "_ctrl"}, 32'(octl), 32'(expCtrl));
    checkOutput({tag, "_data"}, 32'(od), 32'(expData));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, 32'(ctrl), 32'(NOP));
    checkOutput({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(data_out), 32'h00);
  endtask

  initial begin
    int base, base2, e0;
    int repOff[8];
    repOff = '{0, 10, 13, 16, 19, 22, 25, 28};

    async_reset = 1'b1;
    btn_inc = 1'b0; btn_dec = 1'b0; btn_ld = 1'b0; btn_clr = 1'b0;
    sw = 8'h00;

    // Reset state.
    applyStimulus(3);
    checkIdleOutputs("reset");
    async_reset = 1'b0;
    applyStimulus(5);
    checkIdleOutputs("after_reset");

    // Bounce: 3 high, 1 low, then steady high; final high captured at e0+5.
    $display("[TB] bounce");
    base = pulseCyc.size();
    e0 = cyc;
    btn_inc = 1'b1;
    applyStimulus(3);
    btn_inc = 1'b0;
    applyStimulus(1);
    btn_inc = 1'b1;
    applyStimulus(8);
    btn_inc = 1'b0;
    applyStimulus(30);
    checkCount("bounce_count", base, 1);
    checkPulse("bounce", base, e0 + 11, INC, 8'h00);

    // Load captures the switches and holds them afterwards.
    $display("[TB] load");
    base = pulseCyc.size();
    e0 = cyc;
    sw = 8'hA5;
    btn_ld = 1'b1;
    applyStimulus(20);
    btn_ld = 1'b0;
    applyStimulus(15);
    sw = 8'h3C;
    applyStimulus(10);
    checkOutput("load_hold", 32'(data_out), 32'hA5);
    checkCount("load_count", base, 1);
    checkPulse("load", base, e0 + 7, LD, 8'hA5);

    // Auto-repeat; the release reaches the stable level in the cycle the
    // period timer sits at its threshold, so no pulse follows T+28.
    $display("[TB] auto-repeat");
    base = pulseCyc.size();
    e0 = cyc;
    btn_dec = 1'b1;
    applyStimulus(31);
    btn_dec = 1'b0;
    applyStimulus(25);
    checkCount("repeat_count", base, 8);
    for (int i = 0; i < 8; i++)
      checkPulse($sformatf("repeat_%0d", i), base + i, e0 + 7 + repOff[i], DEC, 8'hA5);

    // Simultaneous INC/DEC/CLR: CLR only, nothing more while INC/DEC held.
    $display("[TB] simultaneous");
    base = pulseCyc.size();
    e0 = cyc;
    btn_inc = 1'b1; btn_dec = 1'b1; btn_clr = 1'b1;
    applyStimulus(25);
    btn_clr = 1'b0;
    applyStimulus(20);
    checkCount("simul_count", base, 1);
    checkPulse("simul", base, e0 + 7, CLR, 8'hA5);
    btn_inc = 1'b0; btn_dec = 1'b0;
    applyStimulus(12);
    base2 = pulseCyc.size();
    e0 = cyc;
    btn_inc = 1'b1;
    applyStimulus(8);
    btn_inc = 1'b0;
    applyStimulus(20);
    checkCount("repress_count", base2, 1);
    checkPulse("repress", base2, e0 + 7, INC, 8'hA5);

    // Preempt: CLR press lands while INC is in REPEAT after the T+19 pulse.
    $display("[TB] preempt");
    base = pulseCyc.size();
    e0 = cyc;
    btn_inc = 1'b1;
    applyStimulus(21);
    btn_clr = 1'b1;
    applyStimulus(20);
    btn_clr = 1'b0;
    applyStimulus(15);
    btn_inc = 1'b0;
    applyStimulus(15);
    checkCount("preempt_count", base, 6);
    checkPulse("preempt_inc0", base + 0, e0 + 7, INC, 8'hA5);
    checkPulse("preempt_inc1", base + 1, e0 + 17, INC, 8'hA5);
    checkPulse("preempt_inc2", base + 2, e0 + 20, INC, 8'hA5);
    checkPulse("preempt_inc3", base + 3, e0 + 23, INC, 8'hA5);
    checkPulse("preempt_inc4", base + 4, e0 + 26, INC, 8'hA5);
    checkPulse("preempt_clr", base + 5, e0 + 28, CLR, 8'hA5);

    // Reset mid-operation with buttons toggling, INC held through reset.
    $display("[TB] mid-op reset");
    base = pulseCyc.size();
    e0 = cyc;
    btn_inc = 1'b1;
    applyStimulus(12);
    checkCount("preres_count", base, 1);
    checkPulse("preres", base, e0 + 7, INC, 8'hA5);
    async_reset = 1'b1;
    #1;
    checkIdleOutputs("async_reset");
    for (int i = 0; i < 6; i++) begin
      btn_ld  = ~btn_ld;
      btn_clr = ~btn_clr;
      applyStimulus(1);
      checkIdleOutputs($sformatf("in_reset_%0d", i));
    end
    btn_ld = 1'b0; btn_clr = 1'b0;
    async_reset = 1'b0;
    e0 = cyc;
    applyStimulus(6);
    checkIdleOutputs("post_reset_quiet");
    checkCount("post_reset_none", base, 1);
    applyStimulus(2);
    btn_inc = 1'b0;
    applyStimulus(25);
    checkCount("post_reset_count", base, 2);
    checkPulse("post_reset", base + 1, e0 + 7, INC, 8'h00);
    checkOutput("post_reset_data", 32'(data_out), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_cmd_driver.md
# reg_cmd_driver

Front-end controller that turns raw DE0 push-buttons and slide switches into clean, one-cycle command codes for the `register` block's `ctrl`/`data_input` port pair. It synchronizes and debounces four buttons, detects presses, and arbitrates simultaneous presses. It issues `REG_CTRL_INC`/`DEC`/`LD`/`CLR` pulses, with auto-repeat while INC or DEC is held. It sits between board I/O and the register instance in the top level and shares the register's clock.

## Interface
- `WIDTH`, 8: data path width; equals the driven register's `WIDTH`.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); minimum 1.
- `REPEAT_DELAY`, 25000000: cycles from the first INC/DEC issue to the first repeat; minimum 2.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeats; minimum 2.
- `clk`  in  1  system clock; all state on its rising edge.
- `async_reset`  in  1  reset; asynchronous, active-high.
- `btn_inc`, `btn_dec`, `btn_ld`, `btn_clr`  in  1 each  raw asynchronous buttons, 1 = pressed.
- `sw`  in  WIDTH  raw asynchronous switches; load value.
- `ctrl`  out  `REG_CTRL_WIDTH`  command to register; `REG_CTRL_NOP` when idle.
- `data_out`  out  WIDTH  value for register `data_input`.
- `cmd_valid`  out  1  high exactly in cycles where `ctrl` != `REG_CTRL_NOP`.

## Operation
- Reset values: `ctrl` = `REG_CTRL_NOP`, `data_out` = 0, `cmd_valid` = 0, all sync/stable flops 0, counters 0, FSM = IDLE.
- Sync: each button and each `sw` bit passes through a 2-flop synchronizer (`s1`, `s2`).
- Debounce, per button: counter clears whenever `s2` == stable level. Otherwise it increments. When it reaches `DEBOUNCE_CYCLES` the stable level takes `s2` and the counter clears. A glitch shorter than `DEBOUNCE_CYCLES` never changes the stable level.
- Press event: stable level 0->1, one cycle wide. Release events generate nothing.
- Arbitration among press events in the same cycle: CLR > LD > DEC > INC. Losers are dropped, not queued.
- FSM states: IDLE, ISSUE, DELAY, REPEAT, WAIT_REL.
  - IDLE: press event -> ISSUE with latched command.
  - ISSUE (one cycle): `ctrl` = command, `cmd_valid` = 1. For LD, `data_out` <= synchronized `sw` on the ISSUE edge. `data_out` holds its value in all other cycles. Next state: DELAY for INC/DEC (timer cleared), WAIT_REL for LD/CLR.
  - DELAY: if the held button's stable level is 0 -> IDLE. Else if timer = `REPEAT_DELAY`-2 -> ISSUE (repeat). Else timer++.
  - REPEAT: same as DELAY but the threshold is `REPEAT_PERIOD`-2. ISSUE after a repeat returns to REPEAT, not DELAY.
  - WAIT_REL: -> IDLE when the issuing button's stable level is 0.
- Preemption: a CLR press event in DELAY, REPEAT or WAIT_REL -> ISSUE CLR, and the previous command is abandoned. All other press events outside IDLE are ignored.
- `ctrl`, `cmd_valid` and `data_out` are registered outputs with no combinational path from inputs.

## Timing
- Press latency: let N0 be the edge where `s1` first captures 1 and the level stays high. Stable goes to 1 at edge N0+1+`DEBOUNCE_CYCLES`. FSM enters ISSUE at edge N0+2+`DEBOUNCE_CYCLES`. `cmd_valid` is high for exactly the following cycle.
- Auto-repeat: the first ISSUE is at cycle T. Repeats are at T+`REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles after that, while the button stays stably pressed.
- Release during DELAY/REPEAT: no further issue after the stable level drops, including a stable drop in the same cycle the timer hits its threshold (release wins).
- Reset mid-operation: outputs return to reset values immediately (asynchronous). No command is issued after reset deasserts unless a new stable 0->1 transition occurs. A button held through reset re-debounces and issues once.
- Throughput: at most one command per 2 cycles. `cmd_valid` is never high in two consecutive cycles.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `WIDTH`=8.
- Reset: hold `async_reset`=1 mid-simulation with buttons toggling -> `ctrl`=NOP, `cmd_valid`=0, `data_out`=0x00 throughout reset and until a fresh debounced press.
- Bounce: `btn_inc` toggles high 3 cycles, low 1, high 3, then steady -> exactly one INC pulse, 2+4 cycles after `s1` captures the final steady high.
- Load: `sw`=0xA5, press `btn_ld` 20 cycles -> one `REG_CTRL_LD` pulse with `data_out`=0xA5. Change `sw` to 0x3C afterwards -> `data_out` stays 0xA5.
- Auto-repeat: hold `btn_dec` 30 cycles after the first issue at T -> DEC pulses at T, T+10, T+13, ..., T+28. No pulse after the release is debounced.
- Simultaneous: INC, DEC and CLR reach stable high in the same cycle -> single CLR pulse, then no INC/DEC until released and repressed.
- Preempt: hold `btn_inc` through repeats, press `btn_clr` -> CLR issued on schedule and no further INC pulses while the CLR button is held.
